// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, funct3 codes and defaults for the data-memory responder.
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h0100_0000;
  localparam int DEF_MEM_DEPTH = 1048576;
  function automatic logic [2:0] f3_size(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 3'd1 : (f3[1:0] == 2'd1) ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/dmem_lane_fmt.sv
// dmem_lane_fmt: funct3/alignment legality and load lane extraction with sign/zero extension.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_word,
  output logic [31:0] o_rdata,
  output logic        o_illegal
);
  logic [2:0]  w_sz;
  logic        w_f3_ok;
  logic        w_misal;
  logic [31:0] w_sh;
  always_comb begin
    w_sz      = f3_size(i_funct3);
    w_f3_ok   = (i_funct3 inside {F3_B, F3_H, F3_W}) || (!i_we && (i_funct3 inside {F3_BU, F3_HU}));
    w_misal   = (w_sz == 3'd2 && i_off[0]) || (w_sz == 3'd4 && i_off != 2'd0);
    o_illegal = !w_f3_ok || w_misal;
    // i_word is the aligned word; shift the addressed lane down to bit 0
    w_sh      = i_word >> {i_off, 3'b000};
    o_rdata   = o_illegal            ? '0 :
                i_funct3 == F3_B     ? {{24{w_sh[7]}}, w_sh[7:0]} :
                i_funct3 == F3_H     ? {{16{w_sh[15]}}, w_sh[15:0]} :
                i_funct3 == F3_BU    ? {24'd0, w_sh[7:0]} :
                i_funct3 == F3_HU    ? {16'd0, w_sh[15:0]} : w_sh;
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store target with fixed wait states
// over a byte-addressed little-endian array.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int                AWIDTH    = 32,
  parameter int                DWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = AWIDTH'(DEF_BASE_ADDR),
  parameter int                MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int                LATENCY   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic [DWIDTH-1:0] req_wdata_i,
  input  logic [2:0]        req_funct3_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DWIDTH-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);
  localparam int OW = $clog2(MEM_DEPTH);
  state_t            r_state, w_next;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [AWIDTH-1:0] r_addr;
  logic [DWIDTH-1:0] r_wdata;
  logic [2:0]        r_f3;
  logic [7:0]        r_mem [MEM_DEPTH];
  logic [AWIDTH-1:0] w_off;
  logic [OW-1:0]     w_idx, w_wbase;
  logic [31:0]       w_word, w_fmt;
  logic [2:0]        w_sz;
  logic              w_illegal, w_err, w_access;
  always_comb begin
    w_off    = r_addr - BASE_ADDR;
    w_sz     = f3_size(r_f3);
    w_idx    = w_off[OW-1:0];
    w_wbase  = {w_idx[OW-1:2], 2'b00};
    w_word   = {r_mem[w_wbase + OW'(3)], r_mem[w_wbase + OW'(2)], r_mem[w_wbase + OW'(1)], r_mem[w_wbase]};
    w_err    = w_illegal || (r_addr < BASE_ADDR) ||
               (({1'b0, w_off} + (AWIDTH+1)'(w_sz)) > (AWIDTH+1)'(MEM_DEPTH));
    w_access = (r_state == WAIT) && (r_cnt == 4'd0);
  end
  dmem_lane_fmt u_fmt (
    .i_we      (r_we),
    .i_funct3  (r_f3),
    .i_off     (w_off[1:0]),
    .i_word    (w_word),
    .o_rdata   (w_fmt),
    .o_illegal (w_illegal)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = (r_state == IDLE) ? (req_valid_i ? WAIT : IDLE) :
             (r_state == WAIT) ? ((r_cnt == 4'd0) ? RESP : WAIT) :
                                 (rsp_ready_i ? IDLE : RESP);
  end
  always_comb begin
    req_ready_o = (r_state == IDLE);
    rsp_valid_o = (r_state == RESP);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_f3        <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      if (r_state == IDLE && req_valid_i) begin
        r_we    <= req_we_i;
        r_addr  <= req_addr_i;
        r_wdata <= req_wdata_i;
        r_f3    <= req_funct3_i;
        r_cnt   <= 4'(LATENCY);
      end else if (r_state == WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access) begin
        rsp_rdata_o <= (r_we || w_err) ? '0 : w_fmt;
        rsp_err_o   <= w_err;
      end
    end
  end
  // Array is deliberately not reset; a reset forces IDLE so no write can slip through
  always_ff @(posedge clk) begin
    if (w_access && r_we && !w_err)
      for (int k = 0; k < 4; k++)
        if (3'(k) < w_sz) r_mem[w_idx + OW'(k)] <= r_wdata[8*k +: 8];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed + randomized transactions checked against a byte-map reference model.
module tb_dmem_responder;
  localparam int     LAT   = 2;
  localparam longint BASE  = 64'h0100_0000;
  localparam longint DEPTH = 1048576;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid_i = 1'b0, req_we_i = 1'b0, rsp_ready_i = 1'b0;
  logic [31:0] req_addr_i = '0, req_wdata_i = '0;
  logic [2:0]  req_funct3_i = '0;
  logic        req_ready_o, rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  int          checks = 0, errors = 0;
  logic [7:0]  mdl [longint];
  always #5 clk = ~clk;
  dmem_responder #(.LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_funct3_i(req_funct3_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic void model(input bit we, input longint a, input logic [31:0] d, input logic [2:0] f3,
                                output logic err, output logic [31:0] rd);
    int     sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    bit     ok  = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    longint off = a - BASE;
    longint v   = 0;
    err = !ok || a < BASE || off + sz > DEPTH || (a % sz) != 0;
    rd  = '0;
    if (err) return;
    for (int i = 0; i < sz; i++)
      if (we) mdl[off + i] = d[8*i +: 8];
      else    v = v | (longint'(mdl[off + i]) << (8 * i));
    if (!we) begin
      if (f3 < 3'd4 && sz < 4 && v[8*sz-1]) v = v - (64'sd1 << (8 * sz));
      rd = v[31:0];
    end
  endfunction
  task automatic xact(input bit we, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                      input int stall, input string tag, output logic [31:0] got);
    logic        err_e;
    logic [31:0] rd_e;
    int          n;
    model(we, longint'(a), d, f3, err_e, rd_e);
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = a; req_wdata_i = d; req_funct3_i = f3;
    n = 0;
    while (!req_ready_o && n < 20) begin @(negedge clk); n++; end
    chk({tag, ".accept"}, 32'(n < 20), 32'd1);
    @(posedge clk); #1 req_valid_i = 1'b0;
    n = 0;
    while (!rsp_valid_o && n < 40) begin @(posedge clk); #1; n++; end
    chk({tag, ".lat"}, 32'(n), 32'(LAT + 1));
    repeat (stall) begin @(posedge clk); #1; end
    chk({tag, ".valid"}, 32'(rsp_valid_o), 32'd1);
    chk({tag, ".err"}, 32'(rsp_err_o), 32'(err_e));
    chk({tag, ".rdata"}, rsp_rdata_o, rd_e);
    got = rsp_rdata_o;
    rsp_ready_i = 1'b1;
    @(posedge clk); #1 rsp_ready_i = 1'b0;
    chk({tag, ".idle"}, {30'd0, rsp_valid_o, req_ready_o}, 32'd1);
  endtask
  initial begin
    logic [31:0] g, hold;
    logic        e;
    int          n;
    repeat (2) @(negedge clk);
    chk("rst", {29'd0, req_ready_o, rsp_valid_o, rsp_err_o}, 32'h4);
    chk("rst.rdata", rsp_rdata_o, 32'd0);
    rst_n = 1'b1;
    xact(1, 32'h0100_0010, 32'hDEAD_BEEF, 3'd2, 0, "sw", g);
    xact(0, 32'h0100_0010, 32'h0, 3'd2, 0, "lw", g);      chk("lw.lit", g, 32'hDEAD_BEEF);
    xact(0, 32'h0100_0013, 32'h0, 3'd0, 1, "lb", g);      chk("lb.lit", g, 32'hFFFF_FFDE);
    xact(0, 32'h0100_0013, 32'h0, 3'd4, 0, "lbu", g);     chk("lbu.lit", g, 32'h0000_00DE);
    xact(0, 32'h0100_0012, 32'h0, 3'd1, 2, "lh", g);      chk("lh.lit", g, 32'hFFFF_DEAD);
    xact(0, 32'h0100_0012, 32'h0, 3'd5, 0, "lhu", g);     chk("lhu.lit", g, 32'h0000_DEAD);
    xact(1, 32'h0100_0010, 32'hAAAA_1234, 3'd1, 0, "sh", g);
    xact(0, 32'h0100_0010, 32'h0, 3'd2, 0, "lw2", g);     chk("lw2.lit", g, 32'hDEAD_1234);
    xact(1, 32'h0100_0011, 32'hBBBB_BB77, 3'd0, 0, "sb", g);
    xact(0, 32'h0100_0010, 32'h0, 3'd2, 0, "lw3", g);     chk("lw3.lit", g, 32'hDEAD_7734);
    xact(0, 32'h0100_0002, 32'h0, 3'd2, 0, "mis", g);
    xact(1, 32'h00FF_FFFC, 32'h1111_1111, 3'd2, 0, "below", g);
    xact(0, 32'h0100_0010, 32'h0, 3'd3, 0, "f3bad", g);
    xact(1, 32'h0100_0010, 32'h2222_2222, 3'd4, 0, "sbu", g);
    xact(0, 32'h0100_0010, 32'h0, 3'd2, 0, "lw4", g);     chk("lw4.lit", g, 32'hDEAD_7734);
    xact(1, 32'(BASE + DEPTH - 4), 32'hCAFE_F00D, 3'd2, 0, "sw.top", g);
    xact(1, 32'(BASE + DEPTH - 2), 32'h0000_BEEF, 3'd1, 0, "sh.top", g);
    xact(1, 32'(BASE + DEPTH - 2), 32'h3333_3333, 3'd2, 0, "sw.mis", g);
    xact(1, 32'(BASE + DEPTH), 32'h4444_4444, 3'd0, 0, "sb.oor", g);
    xact(0, 32'(BASE + DEPTH), 32'h0, 3'd2, 0, "lw.oor", g);
    xact(0, 32'(BASE + DEPTH - 4), 32'h0, 3'd2, 0, "lw.top", g); chk("lw.top.lit", g, 32'hBEEF_F00D);
    // response backpressure with a new request waiting
    model(0, BASE + 'h10, 32'h0, 3'd2, e, hold);
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h0100_0010; req_funct3_i = 3'd2;
    @(posedge clk); #1 req_addr_i = 32'h0100_0012; req_funct3_i = 3'd5;
    n = 0;
    while (!rsp_valid_o && n < 40) begin @(posedge clk); #1; n++; end
    chk("bp.lat", 32'(n), 32'(LAT + 1));
    for (int i = 0; i < 5; i++) begin
      chk("bp.valid", {30'd0, rsp_valid_o, req_ready_o}, 32'd2);
      chk("bp.rdata", rsp_rdata_o, hold);
      @(posedge clk); #1;
    end
    rsp_ready_i = 1'b1;
    @(posedge clk); #1 rsp_ready_i = 1'b0;
    chk("bp.hs", {30'd0, rsp_valid_o, req_ready_o}, 32'd1);
    @(posedge clk); #1 req_valid_i = 1'b0;
    chk("bp.acc", 32'(req_ready_o), 32'd0);
    model(0, BASE + 'h12, 32'h0, 3'd5, e, hold);
    n = 0;
    while (!rsp_valid_o && n < 40) begin @(posedge clk); #1; n++; end
    chk("bp2.lat", 32'(n), 32'(LAT + 1));
    chk("bp2.rdata", rsp_rdata_o, hold);
    rsp_ready_i = 1'b1;
    @(posedge clk); #1 rsp_ready_i = 1'b0;
    // reset during WAIT discards a pending store
    xact(1, 32'h0100_0020, 32'h1122_3344, 3'd2, 0, "sw.old", g);
    xact(0, 32'h0100_0020, 32'h0, 3'd2, 0, "lw.old", g);
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h0100_0020; req_wdata_i = 32'h55; req_funct3_i = 3'd2;
    @(posedge clk); #1 req_valid_i = 1'b0;
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("arst", {29'd0, req_ready_o, rsp_valid_o, rsp_err_o}, 32'h4);
    chk("arst.rdata", rsp_rdata_o, 32'd0);
    @(posedge clk); @(negedge clk) rst_n = 1'b1;
    xact(0, 32'h0100_0020, 32'h0, 3'd2, 0, "lw.kept", g); chk("lw.kept.lit", g, 32'h1122_3344);
    // randomized phase over a prefilled window plus the edges of the map
    for (int i = 0; i < 16; i++)
      xact(1, 32'(BASE + 'h100 + 4 * i), $urandom, 3'd2, 0, "fill", g);
    for (int i = 0; i < 40; i++) begin
      int sel = $urandom_range(0, 9);
      logic [31:0] a = (sel == 0) ? 32'(BASE - 4) : (sel == 1) ? 32'(BASE + DEPTH - 2) :
                                    32'(BASE + 'h100 + $urandom_range(0, 63));
      xact(1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)), $urandom_range(0, 3), "rnd", g);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
